// File: rtl/sky130_sram_port0_ctrl.sv
// rtl/sky130_sram_port0_ctrl.sv - request/response front end for a sky130 single-port SRAM macro (port 0)
// Ports:
//   clk0, rst0            clock (also the macro clock), async active-high reset
//   req_*                 valid/ready request: we, wmask, addr, wdata
//   rsp_*                 valid/ready read response, returned in acceptance order
//   sram_*                registered macro controls (csb0/web0 active-low), sram_dout0 macro read data
//   init_done             zero-fill finished, controller accepting requests
module sky130_sram_port0_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int NUM_WMASKS = 4,
    parameter bit INIT_EN    = 1'b1
) (
    input  logic                  clk0,
    input  logic                  rst0,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [NUM_WMASKS-1:0] req_wmask,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  sram_csb0,
    output logic                  sram_web0,
    output logic [NUM_WMASKS-1:0] sram_wmask0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [DATA_WIDTH-1:0] sram_din0,
    input  logic [DATA_WIDTH-1:0] sram_dout0,
    output logic                  init_done
);

    localparam int         RAM_DEPTH  = 1 << ADDR_WIDTH;
    localparam int         FIFO_DEPTH = 4;
    localparam logic [0:0] ST_INIT    = 1'b0;
    localparam logic [0:0] ST_RUN     = 1'b1;

    logic [0:0]            state;
    logic [ADDR_WIDTH-1:0] init_addr;
    logic                  rd_capture;
    logic [2:0]            credits;
    logic [2:0]            fifo_count;
    logic [1:0]            wr_ptr;
    logic [1:0]            rd_ptr;
    logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];

    logic running;
    logic accept;
    logic rd_accept;
    logic pop;
    logic rd_issue;

    // Gating with rst0 keeps req_ready/init_done low during reset even
    // when INIT_EN = 0 puts the state register straight into RUN.
    assign running   = (state == ST_RUN) && !rst0;
    assign init_done = running;
    assign req_ready = running && (req_we || (credits < 3'd4));
    assign accept    = req_valid && req_ready;
    assign rd_accept = accept && !req_we;
    assign rsp_valid = (fifo_count != 3'd0);
    assign pop       = rsp_valid && rsp_ready;
    assign rsp_rdata = fifo_mem[rd_ptr];

    // A read is on the macro pins this cycle; its data appears on
    // sram_dout0 in time for the edge after next.
    assign rd_issue  = !sram_csb0 && sram_web0;

    always_ff @(posedge clk0 or posedge rst0) begin
        if (rst0) begin
            state       <= INIT_EN ? ST_INIT : ST_RUN;
            init_addr   <= '0;
            sram_csb0   <= 1'b1;
            sram_web0   <= 1'b1;
            sram_wmask0 <= '0;
            sram_addr0  <= '0;
            sram_din0   <= '0;
        end else if (state == ST_INIT) begin
            sram_csb0   <= 1'b0;
            sram_web0   <= 1'b0;
            sram_wmask0 <= '1;
            sram_addr0  <= init_addr;
            sram_din0   <= '0;
            init_addr   <= init_addr + 1'b1;
            if (init_addr == ADDR_WIDTH'(RAM_DEPTH - 1)) begin
                state <= ST_RUN;
            end
        end else if (accept) begin
            sram_csb0   <= 1'b0;
            sram_web0   <= !req_we;
            sram_wmask0 <= req_we ? req_wmask : '0;
            sram_addr0  <= req_addr;
            sram_din0   <= req_we ? req_wdata : '0;
        end else begin
            sram_csb0   <= 1'b1;
            sram_web0   <= 1'b1;
            sram_wmask0 <= '0;
        end
    end

    // Credits cover reads in the macro pipeline plus FIFO occupancy, so a
    // captured read always finds a free FIFO slot.
    always_ff @(posedge clk0 or posedge rst0) begin
        if (rst0) begin
            rd_capture <= 1'b0;
            credits    <= '0;
        end else begin
            rd_capture <= rd_issue;
            case ({rd_accept, pop})
                2'b10:   credits <= credits + 3'd1;
                2'b01:   credits <= credits - 3'd1;
                default: credits <= credits;
            endcase
        end
    end

    always_ff @(posedge clk0 or posedge rst0) begin
        if (rst0) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem[i] <= '0;
            end
        end else begin
            if (rd_capture) begin
                fifo_mem[wr_ptr] <= sram_dout0;
                wr_ptr           <= wr_ptr + 2'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            case ({rd_capture, pop})
                2'b10:   fifo_count <= fifo_count + 3'd1;
                2'b01:   fifo_count <= fifo_count - 3'd1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

endmodule

// File: doc/sky130_sram_port0_ctrl.md
SKY130_SRAM_PORT0_CTRL -- requirements
Module: sky130_sram_port0_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, meaning request/response and macro data width.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 10, meaning word address width; RAM_DEPTH = 1 << ADDR_WIDTH.
REQ-003 The block SHALL have parameter NUM_WMASKS, default 4, meaning byte-lane write-mask width (DATA_WIDTH/8).
REQ-004 The block SHALL have parameter INIT_EN, default 1, meaning zero-fill the macro after reset when 1.
REQ-005 The block SHALL have one clock and an asynchronous, active-high reset, as the following two port lines state.
REQ-006 clk0  input  1  single clock; all state changes on rising edge; same clock drives the macro clk0.
REQ-007 rst0  input  1  asynchronous, active-high reset.
REQ-008 req_valid  input  1  request present.
REQ-009 req_ready  output  1  request accepted when req_valid && req_ready at a rising edge ("accept").
REQ-010 req_we  input  1  1 = write, 0 = read.
REQ-011 req_wmask  input  NUM_WMASKS  byte-lane enables for writes.
REQ-012 req_addr  input  ADDR_WIDTH  word address.
REQ-013 req_wdata  input  DATA_WIDTH  write data.
REQ-014 rsp_valid  output  1  read data available.
REQ-015 rsp_ready  input  1  response consumed when rsp_valid && rsp_ready at a rising edge.
REQ-016 rsp_rdata  output  DATA_WIDTH  read data, in request order.
REQ-017 sram_csb0 / sram_web0  output  1 each  macro active-low chip select / write enable.
REQ-018 sram_wmask0 / sram_addr0 / sram_din0  output  NUM_WMASKS / ADDR_WIDTH / DATA_WIDTH  macro mask, address, write data.
REQ-019 sram_dout0  input  DATA_WIDTH  macro port-0 read data.
REQ-020 init_done  output  1  high once zero-fill is complete (or immediately after reset when INIT_EN = 0).

Function
REQ-021 All sram_* outputs SHALL come directly from flops (issue register); no combinational path from req_* to sram_*.
REQ-022 States SHALL be INIT and RUN; reset enters INIT when INIT_EN = 1, else RUN.
REQ-023 INIT: one write per cycle, addresses 0 to RAM_DEPTH-1 ascending, din 0, wmask all ones, web0 0, csb0 0; req_ready = 0.
REQ-024 INIT -> RUN SHALL occur after the write to RAM_DEPTH-1 is issued; init_done rises in the first RUN cycle and stays high until reset.
REQ-025 RUN: an accepted request SHALL be presented on sram_* in the cycle after accept; otherwise sram_csb0 = 1, sram_web0 = 1.
REQ-026 Reads SHALL present sram_web0 = 1 and sram_wmask0 = 0; writes SHALL present sram_web0 = 0 and pass req_wmask/req_wdata unchanged.
REQ-027 A write with req_wmask = 0 SHALL still be accepted and issued (no data change); it produces no response.
REQ-028 Read data SHALL be sampled from sram_dout0 at the second rising edge after accept and pushed into a 4-entry response FIFO; rsp_valid rises the cycle after that edge if the FIFO was empty (accept-to-rsp_valid latency = 2 cycles).
REQ-029 A read credit counter (reads issued-but-not-captured plus FIFO occupancy, 0..4) SHALL gate reads: req_ready = RUN && (req_we || credits < 4) — req_ready may depend on req_we; writes never consume credits.
REQ-030 Simultaneous read accept and response pop SHALL leave credits unchanged; FIFO simultaneous push and pop SHALL keep occupancy unchanged.
REQ-031 A read accepted in the cycle after a write accept to the same address SHALL return the newly written bytes (macro writes on the falling edge before the read is sampled).
REQ-032 rsp_rdata SHALL be stable while rsp_valid && !rsp_ready.
REQ-033 Responses SHALL be returned in acceptance order; FIFO pointers wrap modulo 4.

Reset
REQ-034 On rst0 high, asynchronously: sram_csb0 = 1, sram_web0 = 1, sram_wmask0 = 0, sram_addr0 = 0, sram_din0 = 0, req_ready = 0, rsp_valid = 0, rsp_rdata = 0, init_done = 0, credits = 0, FIFO empty.
REQ-035 Reset asserted mid-INIT or with reads in flight SHALL discard all pending responses and restart zero-fill from address 0 on release.

Verification
REQ-036 Reset release, INIT_EN = 1, RAM_DEPTH = 1024 -> exactly 1024 write issues (addr 0..1023), init_done high after them; then read addr 0x3FF -> rsp_rdata 0x00000000.
REQ-037 Write addr 0x005 data 0xDEADBEEF mask 4'b0101, next cycle read 0x005 -> rsp_rdata 0x00AD00EF, rsp_valid 2 cycles after read accept.
REQ-038 rsp_ready held 0, five back-to-back reads offered -> four accepted, req_ready low for fifth; release rsp_ready -> four responses in order, fifth then accepted.
REQ-039 Alternating read/write stream with rsp_ready toggled every cycle -> no lost or reordered responses; writes accepted while reads are blocked by credits.
REQ-040 rst0 pulsed with 3 reads outstanding -> rsp_valid 0 immediately, sram_csb0 1, no stale response after release, zero-fill restarts at address 0.
